bus_op_sequencer: RTL

- Command-driven sequencer for the shared-bus register datapath: registers A, B and C, temporary T, accumulator AC, and an add/sub ALU.
- Accepts register-transfer commands (ADD, SUB, MOV, NOP) through a valid/ready handshake and buffers them in a 2-entry queue.
- Expands each command into the Wa..Wac / Ra..Rac / S / R control pulses the datapath expects.
- Replaces the fixed-program control unit; sits between a host and the data unit.

---
 rtl/sd_pkg.sv | 73 +++++++
 rtl/cmd_fifo.sv | 77 +++++++
 rtl/bus_op_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the bus-operation sequencer: opcodes, register
// codes, FSM state encoding, the control-output bundle and decode helpers.
package sd_pkg;

    localparam int OPW = 2;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_MOV = 2'd3;

    localparam logic [1:0] REG_A  = 2'd0;
    localparam logic [1:0] REG_B  = 2'd1;
    localparam logic [1:0] REG_C  = 2'd2;
    localparam logic [1:0] REG_AC = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_T = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WRBACK = 3'd3,
        ST_MOVE   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // One bit per datapath control plus the retire/error flags.
    typedef struct packed {
        logic wa;
        logic wb;
        logic wc;
        logic wt;
        logic wac;
        logic ra;
        logic rb;
        logic rc;
        logic rac;
        logic s;
        logic r;
        logic fin;
        logic err;
    } ctrl_t;

    // Bus-drive enables {Ra, Rb, Rc, Rac} for a register select.
    function automatic logic [3:0] rd_dec(input logic [1:0] sel);
        logic [3:0] v;
        case (sel)
            REG_A:   v = 4'b1000;
            REG_B:   v = 4'b0100;
            REG_C:   v = 4'b0010;
            REG_AC:  v = 4'b0001;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    // Write enables {Wa, Wb, Wc}; AC is only ever written by the ALU.
    function automatic logic [2:0] wr_dec(input logic [1:0] sel);
        logic [2:0] v;
        case (sel)
            REG_A:   v = 3'b100;
            REG_B:   v = 3'b010;
            REG_C:   v = 3'b001;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // A MOV into AC, or onto itself, cannot be carried out on the bus.
    function automatic logic mov_illegal(input logic [1:0] src1, input logic [1:0] dst);
        return (dst == REG_AC) || (src1 == dst);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue with occupancy count and reset flush.
// Depth must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Next pointers and occupancy; pushes while full and pops while empty are ignored.
    always_comb begin
        do_push_s = push && !full_s;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - (AW+1)'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and count state; reset flushes the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/bus_op_sequencer.sv
// Command-driven sequencer for the shared-bus A/B/C/T/AC datapath.
// Commands enter a small queue and are expanded into per-cycle register
// read/write and ALU controls. Outputs are flops loaded from the decode of
// the next state, so they carry no combinational path from the inputs.
// Optional macro SEQ_ERR_EN: flag illegal MOVs on err during their DONE cycle.
module bus_op_sequencer
    import sd_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int RW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [RW-1:0] cmd_src1,
    input  logic [RW-1:0] cmd_src2,
    input  logic [RW-1:0] cmd_dst,
    output logic          Wa,
    output logic          Wb,
    output logic          Wc,
    output logic          Wt,
    output logic          Wac,
    output logic          Ra,
    output logic          Rb,
    output logic          Rc,
    output logic          Rac,
    output logic          S,
    output logic          R,
    output logic          busy,
    output logic          fin,
    output logic          err
);
    localparam int CW   = OPW + 3 * RW;
    localparam int CNTW = $clog2(QDEPTH) + 1;

    logic [CW-1:0]   head_s;
    logic [CNTW-1:0] count_s;
    logic            empty_s;
    logic            pop_s;

    state_e          state_q, state_d;
    logic [CW-1:0]   cmd_q, cmd_d;
    ctrl_t           ctrl_q, ctrl_d;

    logic [1:0]      head_op_s;
    logic [RW-1:0]   head_src1_s;
    logic [RW-1:0]   head_dst_s;
    logic [1:0]      cur_op_s;
    logic [RW-1:0]   cur_src1_s;
    logic [RW-1:0]   cur_src2_s;
    logic [RW-1:0]   cur_dst_s;

    cmd_fifo #(
        .DW    (CW),
        .DEPTH (QDEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_src1, cmd_src2, cmd_dst}),
        .pop       (pop_s),
        .head      (head_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    assign cmd_ready   = (count_s != CNTW'(QDEPTH));
    assign busy        = (state_q != ST_IDLE) || !empty_s;

    assign head_op_s   = head_s[CW-1 -: OPW];
    assign head_src1_s = head_s[3*RW-1 -: RW];
    assign head_dst_s  = head_s[RW-1:0];

    assign cur_op_s    = cmd_d[CW-1 -: OPW];
    assign cur_src1_s  = cmd_d[3*RW-1 -: RW];
    assign cur_src2_s  = cmd_d[2*RW-1 -: RW];
    assign cur_dst_s   = cmd_d[RW-1:0];

    // Next state and command latch; the queue head is taken only from IDLE.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    cmd_d = head_s;
                    case (head_op_s)
                        OP_NOP:  state_d = ST_DONE;
                        OP_MOV:  state_d = mov_illegal(head_src1_s, head_dst_s) ? ST_DONE : ST_MOVE;
                        default: state_d = ST_LOAD_T;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_T: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WRBACK;
            ST_WRBACK: state_d = ST_DONE;
            ST_MOVE:   state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control decode for the state about to be entered, using the command it will hold.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_IDLE: begin
                ctrl_d = '0;
            end
            ST_LOAD_T: begin
                {ctrl_d.ra, ctrl_d.rb, ctrl_d.rc, ctrl_d.rac} = rd_dec(cur_src1_s);
                ctrl_d.wt = 1'b1;
            end
            ST_EXEC: begin
                {ctrl_d.ra, ctrl_d.rb, ctrl_d.rc, ctrl_d.rac} = rd_dec(cur_src2_s);
                ctrl_d.wac = 1'b1;
                if (cur_op_s == OP_SUB) begin
                    ctrl_d.r = 1'b1;
                end else begin
                    ctrl_d.s = 1'b1;
                end
            end
            ST_WRBACK: begin
                // A destination of AC already holds the result after EXEC.
                if (cur_dst_s != REG_AC) begin
                    ctrl_d.rac = 1'b1;
                    {ctrl_d.wa, ctrl_d.wb, ctrl_d.wc} = wr_dec(cur_dst_s);
                end else begin
                    ctrl_d = '0;
                end
            end
            ST_MOVE: begin
                {ctrl_d.ra, ctrl_d.rb, ctrl_d.rc, ctrl_d.rac} = rd_dec(cur_src1_s);
                {ctrl_d.wa, ctrl_d.wb, ctrl_d.wc} = wr_dec(cur_dst_s);
            end
            ST_DONE: begin
                ctrl_d.fin = 1'b1;
`ifdef SEQ_ERR_EN
                ctrl_d.err = (cur_op_s == OP_MOV) && mov_illegal(cur_src1_s, cur_dst_s);
`else
                ctrl_d.err = 1'b0;
`endif
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    // FSM state, latched command and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign Wa  = ctrl_q.wa;
    assign Wb  = ctrl_q.wb;
    assign Wc  = ctrl_q.wc;
    assign Wt  = ctrl_q.wt;
    assign Wac = ctrl_q.wac;
    assign Ra  = ctrl_q.ra;
    assign Rb  = ctrl_q.rb;
    assign Rc  = ctrl_q.rc;
    assign Rac = ctrl_q.rac;
    assign S   = ctrl_q.s;
    assign R   = ctrl_q.r;
    assign fin = ctrl_q.fin;
    assign err = ctrl_q.err;

endmodule
